im_addr_sequencer: RTL and testbench

IM_ADDR_SEQUENCER -- requirements
Module: im_addr_sequencer

---
 rtl/im_addr_sequencer.sv | 146 ++++++++++++++
 tb/tb_im_addr_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_addr_sequencer.sv
// Item-memory address sequencer: walks base + k*stride for num_items addresses
// per pass under valid/ready flow control, optionally looping until stopped.
//
// state | meaning
// IDLE  | waiting for start_i; addr_o and pass_cnt_o hold
// RUN   | presenting addresses, addr_valid_o = 1
// DONE  | single-cycle done_o pulse after a normal single pass
module im_addr_sequencer #(
  parameter int AddrWidth = 8,
  parameter int LenWidth  = 8,
  parameter int PassWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] stride_i,
  input  logic [LenWidth-1:0]  num_items_i,
  input  logic                 loop_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PassWidth-1:0] pass_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] stride_q;
  logic [LenWidth-1:0]  cnt_q;
  logic [LenWidth-1:0]  num_q;
  logic                 loop_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PassWidth-1:0] pass_q;

  logic                 xfer;
  logic [LenWidth-1:0]  cnt_inc;
  logic [LenWidth-1:0]  num_m1;

  assign xfer    = valid_q & addr_ready_i;
  assign cnt_inc = cnt_q + LenWidth'(1);
  assign num_m1  = num_q - LenWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      loop_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q   <= base_addr_i;
            stride_q <= stride_i;
            num_q    <= num_items_i;
            loop_q   <= loop_i;
            pass_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= base_addr_i;
            if (num_items_i != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              last_q  <= (num_items_i == LenWidth'(1));
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            if (last_q) begin
              pass_q <= pass_q + PassWidth'(1);
              if (loop_q) begin
                addr_q <= base_q;
                cnt_q  <= '0;
                last_q <= (num_q == LenWidth'(1));
              end
            end else begin
              addr_q <= addr_q + stride_q;
              cnt_q  <= cnt_inc;
              last_q <= (cnt_inc == num_m1);
            end
          end
          // Stop wins over loop restart and suppresses the done pulse.
          if (stop_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
          end else if (xfer && last_q && !loop_q) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = valid_q;
  assign last_o       = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_cnt_o   = pass_q;

endmodule

// File: tb/tb_im_addr_sequencer.sv
// Self-checking bench for im_addr_sequencer: directed scenarios plus randomized
// sequences compared against an index-based reference model.
module tb_im_addr_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic [7:0]  base_addr_i;
  logic [7:0]  stride_i;
  logic [7:0]  num_items_i;
  logic        loop_i;
  logic [7:0]  addr_o;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pass_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  im_addr_sequencer #(
    .AddrWidth(8),
    .LenWidth (8),
    .PassWidth(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .num_items_i (num_items_i),
    .loop_i      (loop_i),
    .addr_o      (addr_o),
    .addr_valid_o(addr_valid_o),
    .addr_ready_i(addr_ready_i),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_cnt_o  (pass_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Config inputs are scrambled after the start cycle; the DUT must ignore them.
  task automatic do_start(input logic [7:0] b, input logic [7:0] s,
                          input logic [7:0] n, input logic l);
    base_addr_i = b;
    stride_i    = s;
    num_items_i = n;
    loop_i      = l;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    base_addr_i = 8'($urandom);
    stride_i    = 8'($urandom);
    num_items_i = 8'($urandom);
    loop_i      = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b0; stop_i = 1'b0; addr_ready_i = 1'b0;
    base_addr_i = 8'h00; stride_i = 8'h00; num_items_i = 8'h00; loop_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({addr_o, addr_valid_o, last_o, busy_o, done_o, pass_cnt_o} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h v=%b l=%b b=%b d=%b p=%0d expected all zero",
               addr_o, addr_valid_o, last_o, busy_o, done_o, pass_cnt_o);
    end
    #2 rst_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({addr_valid_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got v=%b b=%b d=%b expected 000",
               addr_valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_single_pass();
    addr_ready_i = 1'b1;
    do_start(8'h10, 8'h01, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({addr_valid_o, addr_o, last_o, busy_o, done_o} !== {1'b1, 8'(8'h10 + i), (i == 3), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_pass cyc %0d: got v=%b a=%h l=%b b=%b d=%b expected v=1 a=%h l=%b b=1 d=0",
                 i, addr_valid_o, addr_o, last_o, busy_o, done_o, 8'(8'h10 + i), (i == 3));
      end
      tick();
    end
    checks++;
    if ({addr_valid_o, busy_o, done_o, pass_cnt_o} !== {3'b001, 16'd1}) begin
      errors++;
      $display("FAIL single_pass_done: got v=%b b=%b d=%b p=%0d expected v=0 b=0 d=1 p=1",
               addr_valid_o, busy_o, done_o, pass_cnt_o);
    end
    tick();
    checks++;
    if ({addr_valid_o, done_o, pass_cnt_o} !== {2'b00, 16'd1}) begin
      errors++;
      $display("FAIL single_pass_after: got v=%b d=%b p=%0d expected v=0 d=0 p=1",
               addr_valid_o, done_o, pass_cnt_o);
    end
  endtask

  task automatic test_backpressure_wrap();
    logic [4:0]  rdy_pat  = 5'b10101;
    logic [39:0] exp_addr = {8'hFE, 8'h01, 8'h01, 8'h04, 8'h04};
    logic [4:0]  exp_last = 5'b00011;
    addr_ready_i = 1'b0;
    do_start(8'hFE, 8'h03, 8'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      addr_ready_i = rdy_pat[4-k];
      checks++;
      if ({addr_valid_o, addr_o, last_o} !== {1'b1, exp_addr[39-8*k -: 8], exp_last[4-k]}) begin
        errors++;
        $display("FAIL backpressure cyc %0d: got v=%b a=%h l=%b expected v=1 a=%h l=%b",
                 k, addr_valid_o, addr_o, last_o, exp_addr[39-8*k -: 8], exp_last[4-k]);
      end
      tick();
    end
    checks++;
    if ({addr_valid_o, done_o, pass_cnt_o} !== {2'b01, 16'd1}) begin
      errors++;
      $display("FAIL backpressure_done: got v=%b d=%b p=%0d expected v=0 d=1 p=1",
               addr_valid_o, done_o, pass_cnt_o);
    end
    tick();
  endtask

  task automatic test_loop_stop();
    addr_ready_i = 1'b1;
    do_start(8'h20, 8'h02, 8'd2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({addr_valid_o, addr_o, last_o, pass_cnt_o} !==
          {1'b1, 8'(8'h20 + 2 * (k % 2)), (k % 2 == 1), 16'(k / 2)}) begin
        errors++;
        $display("FAIL loop cyc %0d: got v=%b a=%h l=%b p=%0d expected v=1 a=%h l=%b p=%0d",
                 k, addr_valid_o, addr_o, last_o, pass_cnt_o, 8'(8'h20 + 2 * (k % 2)),
                 (k % 2 == 1), k / 2);
      end
      tick();
    end
    addr_ready_i = 1'b0;
    stop_i = 1'b1;
    checks++;
    if ({addr_valid_o, addr_o, pass_cnt_o} !== {1'b1, 8'h20, 16'd3}) begin
      errors++;
      $display("FAIL loop_before_stop: got v=%b a=%h p=%0d expected v=1 a=20 p=3",
               addr_valid_o, addr_o, pass_cnt_o);
    end
    tick();
    stop_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addr_valid_o, busy_o, done_o, pass_cnt_o} !== {3'b000, 16'd3}) begin
        errors++;
        $display("FAIL loop_stopped cyc %0d: got v=%b b=%b d=%b p=%0d expected v=0 b=0 d=0 p=3",
                 k, addr_valid_o, busy_o, done_o, pass_cnt_o);
      end
      tick();
    end
  endtask

  task automatic test_zero_length();
    addr_ready_i = 1'b1;
    do_start(8'h55, 8'h01, 8'd0, 1'b0);
    checks++;
    if ({addr_valid_o, busy_o, done_o, pass_cnt_o} !== {3'b001, 16'd0}) begin
      errors++;
      $display("FAIL zero_len_done: got v=%b b=%b d=%b p=%0d expected v=0 b=0 d=1 p=0",
               addr_valid_o, busy_o, done_o, pass_cnt_o);
    end
    tick();
    checks++;
    if ({addr_valid_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL zero_len_after: got v=%b b=%b d=%b expected 000",
               addr_valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_ignore_and_reset();
    addr_ready_i = 1'b1;
    do_start(8'h40, 8'h01, 8'd5, 1'b0);
    start_i = 1'b1;
    base_addr_i = 8'h90;
    num_items_i = 8'd2;
    checks++;
    if ({addr_valid_o, addr_o} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL ignore_first: got v=%b a=%h expected v=1 a=40", addr_valid_o, addr_o);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if ({addr_valid_o, addr_o, busy_o} !== {1'b1, 8'h41, 1'b1}) begin
      errors++;
      $display("FAIL ignore_restart: got v=%b a=%h b=%b expected v=1 a=41 b=1",
               addr_valid_o, addr_o, busy_o);
    end
    tick();
    checks++;
    if (addr_o !== 8'h42) begin
      errors++;
      $display("FAIL ignore_third: got a=%h expected a=42", addr_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({addr_o, addr_valid_o, last_o, busy_o, done_o, pass_cnt_o} !== 28'h0) begin
      errors++;
      $display("FAIL async_reset: got a=%h v=%b l=%b b=%b d=%b p=%0d expected all zero",
               addr_o, addr_valid_o, last_o, busy_o, done_o, pass_cnt_o);
    end
    #1 rst_i = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addr_valid_o, busy_o, done_o} !== 3'b000) begin
        errors++;
        $display("FAIL reset_wait cyc %0d: got v=%b b=%b d=%b expected 000",
                 k, addr_valid_o, busy_o, done_o);
      end
      tick();
    end
    do_start(8'h70, 8'h10, 8'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addr_valid_o, addr_o, last_o} !== {1'b1, 8'(8'h70 + 8'h10 * k), (k == 1)}) begin
        errors++;
        $display("FAIL fresh_start cyc %0d: got v=%b a=%h l=%b expected v=1 a=%h l=%b",
                 k, addr_valid_o, addr_o, last_o, 8'(8'h70 + 8'h10 * k), (k == 1));
      end
      tick();
    end
    checks++;
    if ({done_o, pass_cnt_o} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL fresh_done: got d=%b p=%0d expected d=1 p=1", done_o, pass_cnt_o);
    end
    tick();
  endtask

  task automatic test_stop_on_last();
    addr_ready_i = 1'b1;
    do_start(8'h08, 8'h04, 8'd3, 1'b1);
    tick();
    tick();
    stop_i = 1'b1;
    checks++;
    if ({addr_valid_o, addr_o, last_o, pass_cnt_o} !== {1'b1, 8'h10, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL stop_last_pre: got v=%b a=%h l=%b p=%0d expected v=1 a=10 l=1 p=0",
               addr_valid_o, addr_o, last_o, pass_cnt_o);
    end
    tick();
    stop_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addr_valid_o, busy_o, done_o, last_o, pass_cnt_o} !== {4'b0000, 16'd1}) begin
        errors++;
        $display("FAIL stop_last_post cyc %0d: got v=%b b=%b d=%b l=%b p=%0d expected 0 0 0 0 p=1",
                 k, addr_valid_o, busy_o, done_o, last_o, pass_cnt_o);
      end
      tick();
    end
  endtask

  // Reference: address k of a pass is base + k*stride; the model tracks only
  // the item index, pass count and whether a transfer window is open.
  task automatic test_random();
    logic [7:0] b, s, n;
    logic       l, rdy, stp, nd;
    bit         m_valid, m_done;
    int         m_idx, cyc;
    int         m_pass = 1;
    for (int seq = 0; seq < 40; seq++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        stop_i = 1'($urandom);
        tick();
        checks++;
        if ({addr_valid_o, busy_o, done_o, pass_cnt_o} !== {3'b000, 16'(m_pass)}) begin
          errors++;
          $display("FAIL rand_idle seq %0d: got v=%b b=%b d=%b p=%0d expected v=0 b=0 d=0 p=%0d",
                   seq, addr_valid_o, busy_o, done_o, pass_cnt_o, m_pass);
        end
      end
      stop_i = 1'b0;
      b = 8'($urandom);
      s = 8'($urandom);
      n = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      l = 1'($urandom);
      do_start(b, s, n, l);
      m_valid = (n != 8'd0);
      m_done  = (n == 8'd0);
      m_idx   = 0;
      m_pass  = 0;
      for (cyc = 0; cyc < 200; cyc++) begin
        checks++;
        if ({addr_valid_o, busy_o, done_o, pass_cnt_o} !== {m_valid, m_valid, m_done, 16'(m_pass)} ||
            (m_valid && {addr_o, last_o} !== {8'(b + m_idx * s), (m_idx == int'(n) - 1)}) ||
            (!m_valid && last_o !== 1'b0)) begin
          errors++;
          $display("FAIL rand seq %0d cyc %0d: got v=%b b=%b d=%b p=%0d a=%h l=%b expected v=%b d=%b p=%0d a=%h l=%b",
                   seq, cyc, addr_valid_o, busy_o, done_o, pass_cnt_o, addr_o, last_o,
                   m_valid, m_done, m_pass, 8'(b + m_idx * s), m_valid && (m_idx == int'(n) - 1));
        end
        if (!m_valid && !m_done) break;
        rdy = ($urandom_range(0, 3) != 0);
        stp = (l && cyc >= 60) ? 1'b1 : ($urandom_range(0, 24) == 0);
        addr_ready_i = rdy;
        stop_i       = stp;
        start_i      = ($urandom_range(0, 4) == 0);
        nd = 1'b0;
        if (m_valid) begin
          if (rdy) begin
            if (m_idx == int'(n) - 1) begin
              m_pass = (m_pass + 1) % 65536;
              if (stp) m_valid = 1'b0;
              else if (l) m_idx = 0;
              else begin
                m_valid = 1'b0;
                nd = 1'b1;
              end
            end else begin
              m_idx++;
              if (stp) m_valid = 1'b0;
            end
          end else if (stp) begin
            m_valid = 1'b0;
          end
        end
        m_done = nd;
        tick();
      end
      start_i = 1'b0;
      stop_i  = 1'b0;
      if (cyc >= 200) begin
        errors++;
        $display("FAIL rand_timeout seq %0d: sequence did not return to idle within 200 cycles", seq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure_wrap();
    test_loop_stop();
    test_zero_length();
    test_ignore_and_reset();
    test_stop_on_last();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
